// File: rtl/cam_line_capture.sv
// cam_line_capture: assembles camera bytes into pixels and writes each line into a ring of line buffers.
// Optional macro CAM_CAPTURE_HDECIM_EN: horizontal 2:1 decimation (only even-indexed pixels are stored).
module cam_line_capture #(
  parameter  int PIX_BYTES = 2,
  parameter  int LINE_PIX  = 640,
  parameter  int NUM_BUFS  = 2,
  localparam int ADDR_W    = $clog2(LINE_PIX + 1),
  localparam int BUF_W     = $clog2(NUM_BUFS),
  localparam int PIX_W     = 8 * PIX_BYTES
) (
  input  logic                camPCLK,
  input  logic                camRSTn,
  input  logic                camVSYNC,
  input  logic                HREF,
  input  logic [7:0]          pixData,
  input  logic [NUM_BUFS-1:0] bufRelease,
  output logic [PIX_W-1:0]    pixOutput,
  output logic [ADDR_W-1:0]   pixAddr,
  output logic [NUM_BUFS-1:0] writeBuff,
  output logic [NUM_BUFS-1:0] buffClear,
  output logic [BUF_W-1:0]    buffSelect,
  output logic [NUM_BUFS-1:0] bufFull,
  output logic                lineDone,
  output logic [ADDR_W-1:0]   lineLen,
  output logic                frameStart,
  output logic                overflow
);

  // state    | meaning
  // IDLE     | waiting for a line to start (HREF_r rising edge)
  // CLEAR    | one-cycle clear pulse to the selected buffer
  // CAPTURE  | storing pixels of the current line
  // DROP     | selected buffer still unread, line ignored until HREF_r falls
  // LINE_END | commit: lineDone, mark buffer full, advance to next buffer
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CLEAR    = 3'd1;
  localparam logic [2:0] CAPTURE  = 3'd2;
  localparam logic [2:0] DROP     = 3'd3;
  localparam logic [2:0] LINE_END = 3'd4;

  logic                camVSYNC_r;
  logic                HREF_r;
  logic [7:0]          pixData_r;
  logic                vsyncPrev;
  logic                hrefPrev;
  logic                hrefValid;
  logic                hrefArmed;
  logic [2:0]          state;
  logic [2:0]          stateNext;
  logic [1:0]          byteCnt;
  logic [PIX_W-1:0]    pixAsm;
  logic [PIX_W-1:0]    pixAsmNext;
  logic [ADDR_W-1:0]   wrCnt;
  logic [NUM_BUFS-1:0] selOneHot;
  logic [NUM_BUFS-1:0] writeQ;
  logic [NUM_BUFS-1:0] clearQ;
  logic [NUM_BUFS-1:0] bufSetMask;
  logic                hrefRise;
  logic                vsyncFall;
  logic                lineStart;
  logic                lineAccept;
  logic                lineAct;
  logic                inLine;
  logic                pixDone;
  logic                evenOk;
  logic                doWrite;
  logic                pixDiscard;
  logic                ovfSet;

  // A rising edge only counts once HREF_r has been seen low after reset,
  // so a reset released mid-line waits for the next real line start.
  assign hrefRise   = HREF_r & ~hrefPrev & hrefArmed;
  assign vsyncFall  = vsyncPrev & ~camVSYNC_r;
  assign selOneHot  = NUM_BUFS'(1) << buffSelect;
  assign inLine     = (state == CLEAR) || (state == CAPTURE);
  assign lineStart  = ~camVSYNC_r & (state == IDLE) & hrefRise;
  assign lineAccept = lineStart & ~bufFull[buffSelect];
  assign lineAct    = lineAccept | (~camVSYNC_r & inLine);
  assign pixDone    = HREF_r & (byteCnt == 2'(PIX_BYTES - 1));
  assign pixAsmNext = (pixAsm << 8) | PIX_W'(pixData_r);
  assign doWrite    = pixDone & lineAct & evenOk & (wrCnt < ADDR_W'(LINE_PIX));
  assign pixDiscard = pixDone & lineAct & evenOk & (wrCnt >= ADDR_W'(LINE_PIX));
  assign ovfSet     = (lineStart & bufFull[buffSelect]) | pixDiscard;
  assign bufSetMask = ((state == LINE_END) && !camVSYNC_r) ? selOneHot : '0;

  assign writeBuff  = writeQ & {NUM_BUFS{~camVSYNC_r}};
  assign buffClear  = clearQ & {NUM_BUFS{~camVSYNC_r}};
  assign lineDone   = (state == LINE_END) & ~camVSYNC_r;

`ifdef CAM_CAPTURE_HDECIM_EN
  logic pixOdd;

  assign evenOk = ~pixOdd;

  always_ff @(posedge camPCLK or negedge camRSTn) begin
    if (!camRSTn) begin
      pixOdd <= 1'b0;
    end else if (camVSYNC_r || !inLine) begin
      pixOdd <= pixDone & lineAct;
    end else if (pixDone && lineAct) begin
      pixOdd <= ~pixOdd;
    end
  end
`else
  assign evenOk = 1'b1;
`endif

  always_comb begin
    stateNext = state;
    if (camVSYNC_r) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE:     if (hrefRise) stateNext = bufFull[buffSelect] ? DROP : CLEAR;
        CLEAR:    stateNext = CAPTURE;
        CAPTURE:  if (!HREF_r) stateNext = LINE_END;
        DROP:     if (!HREF_r) stateNext = IDLE;
        LINE_END: stateNext = IDLE;
        default:  stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge camPCLK or negedge camRSTn) begin
    if (!camRSTn) begin
      camVSYNC_r <= 1'b0;
      HREF_r     <= 1'b0;
      pixData_r  <= '0;
      vsyncPrev  <= 1'b0;
      hrefPrev   <= 1'b0;
      hrefValid  <= 1'b0;
      hrefArmed  <= 1'b0;
    end else begin
      camVSYNC_r <= camVSYNC;
      HREF_r     <= HREF;
      pixData_r  <= pixData;
      vsyncPrev  <= camVSYNC_r;
      hrefPrev   <= HREF_r;
      hrefValid  <= 1'b1;
      hrefArmed  <= hrefArmed | (hrefValid & ~HREF_r);
    end
  end

  always_ff @(posedge camPCLK or negedge camRSTn) begin
    if (!camRSTn) begin
      state   <= IDLE;
      byteCnt <= '0;
      pixAsm  <= '0;
      wrCnt   <= '0;
    end else begin
      state <= stateNext;
      if (!HREF_r || pixDone) byteCnt <= '0;
      else                    byteCnt <= byteCnt + 2'd1;
      if (HREF_r) pixAsm <= pixAsmNext;
      if (camVSYNC_r || !inLine) wrCnt <= doWrite ? ADDR_W'(1) : '0;
      else if (doWrite)          wrCnt <= wrCnt + ADDR_W'(1);
    end
  end

  always_ff @(posedge camPCLK or negedge camRSTn) begin
    if (!camRSTn) begin
      writeQ    <= '0;
      clearQ    <= '0;
      pixOutput <= '0;
      pixAddr   <= '0;
      lineLen   <= '0;
    end else begin
      writeQ <= doWrite ? selOneHot : '0;
      clearQ <= lineAccept ? selOneHot : '0;
      if (doWrite) begin
        pixOutput <= pixAsmNext;
        pixAddr   <= wrCnt;
      end
      if (state == CAPTURE && stateNext == LINE_END) lineLen <= wrCnt;
    end
  end

  // Commit/release bookkeeping; a set in the same cycle as a release wins.
  always_ff @(posedge camPCLK or negedge camRSTn) begin
    if (!camRSTn) begin
      buffSelect <= '0;
      bufFull    <= '0;
      frameStart <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      bufFull    <= bufSetMask | (bufFull & ~bufRelease);
      frameStart <= vsyncFall;
      if (camVSYNC_r) begin
        buffSelect <= '0;
      end else if (state == LINE_END) begin
        buffSelect <= (buffSelect == BUF_W'(NUM_BUFS - 1)) ? '0 : buffSelect + BUF_W'(1);
      end
      if (ovfSet)         overflow <= 1'b1;
      else if (vsyncFall) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cam_line_capture.sv
// Bench for cam_line_capture (PIX_BYTES=2, LINE_PIX=4, NUM_BUFS=2): vector table,
// hand-written corner sequences and random lines checked against a line-level model.
module tb_cam_line_capture;
  localparam int PB = 2;
  localparam int LP = 4;
  localparam int NB = 2;
  localparam int AW = $clog2(LP + 1);
  localparam int BW = $clog2(NB);

  logic          camPCLK = 1'b0;
  logic          camRSTn = 1'b0;
  logic          camVSYNC = 1'b0;
  logic          HREF = 1'b0;
  logic [7:0]    pixData = '0;
  logic [NB-1:0] bufRelease = '0;
  logic [8*PB-1:0] pixOutput;
  logic [AW-1:0] pixAddr;
  logic [NB-1:0] writeBuff;
  logic [NB-1:0] buffClear;
  logic [BW-1:0] buffSelect;
  logic [NB-1:0] bufFull;
  logic          lineDone;
  logic [AW-1:0] lineLen;
  logic          frameStart;
  logic          overflow;

  cam_line_capture #(.PIX_BYTES(PB), .LINE_PIX(LP), .NUM_BUFS(NB)) dut (
    .camPCLK(camPCLK), .camRSTn(camRSTn), .camVSYNC(camVSYNC), .HREF(HREF),
    .pixData(pixData), .bufRelease(bufRelease), .pixOutput(pixOutput),
    .pixAddr(pixAddr), .writeBuff(writeBuff), .buffClear(buffClear),
    .buffSelect(buffSelect), .bufFull(bufFull), .lineDone(lineDone),
    .lineLen(lineLen), .frameStart(frameStart), .overflow(overflow)
  );

  always #5 camPCLK = ~camPCLK;

  typedef struct {
    logic [NB-1:0] wb;
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  typedef struct {
    bit            vs;
    logic [NB-1:0] rel;
    int            nPix;
    bit            part;
    int            expBuf;
    int            expW;
    int            expLen;
    int            expDone;
    logic [NB-1:0] expFull;
    int            expSel;
    bit            expOvf;
  } vec_t;

  int   nChecks = 0;
  int   nFails = 0;
  wr_t  wrQ[$];
  int   doneCnt = 0;
  int   clrCnt = 0;
  int   fsCnt = 0;
  logic [AW-1:0] lastLen = '0;
  logic [7:0] lb [16];
  vec_t tbl [6];

  logic [NB-1:0] mFull = '0;
  int   mSel = 0;
  bit   mOvf = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    nChecks++;
    if (act !== want) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  always @(negedge camPCLK) begin
    if (camRSTn) begin
      if (writeBuff != '0) wrQ.push_back('{writeBuff, pixAddr, pixOutput});
      if (lineDone) begin
        doneCnt++;
        lastLen = lineLen;
      end
      if (buffClear != '0) clrCnt++;
      if (frameStart) begin
        fsCnt++;
        chk("overflow_at_frameStart", 32'(overflow), 32'd0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic gap(input int n);
    repeat (n) @(negedge camPCLK);
  endtask

  task automatic clearObs();
    wrQ.delete();
    doneCnt = 0;
    clrCnt = 0;
  endtask

  task automatic driveBytes(input int nBytes);
    for (int k = 0; k < nBytes; k++) begin
      @(negedge camPCLK);
      HREF = 1'b1;
      pixData = lb[k];
    end
    @(negedge camPCLK);
    HREF = 1'b0;
    pixData = '0;
  endtask

  task automatic runLine(input int nPix, input bit part);
    clearObs();
    driveBytes(nPix * PB + (part ? 1 : 0));
    gap(6);
  endtask

  task automatic pulseRelease(input logic [NB-1:0] m);
    @(negedge camPCLK);
    bufRelease = m;
    @(negedge camPCLK);
    bufRelease = '0;
    mFull = mFull & ~m;
  endtask

  task automatic vsyncPulse();
    fsCnt = 0;
    @(negedge camPCLK);
    camVSYNC = 1'b1;
    gap(4);
    camVSYNC = 1'b0;
    gap(4);
    chk("frameStart_count", 32'(fsCnt), 32'd1);
    chk("overflow_after_vsync", 32'(overflow), 32'd0);
    mSel = 0;
    mOvf = 1'b0;
  endtask

  task automatic fillPattern();
    for (int k = 0; k < 16; k++) lb[k] = 8'((k + 1) * 17);
  endtask

  task automatic checkWrites(input int nW, input int b);
    chk("write_count", 32'(wrQ.size()), 32'(nW));
    for (int i = 0; i < wrQ.size() && i < nW; i++) begin
      chk("write_strobe", 32'(wrQ[i].wb), 32'(1 << b));
      chk("write_addr", 32'(wrQ[i].addr), 32'(i));
      chk("write_data", 32'(wrQ[i].data), {16'd0, lb[2*i], lb[2*i+1]});
    end
  endtask

  task automatic checkLine(input int nPix);
    bit acc = !mFull[mSel];
    int nW  = acc ? ((nPix > LP) ? LP : nPix) : 0;
    int b   = mSel;
    if (!acc) begin
      mOvf = 1'b1;
    end else begin
      if (nPix > LP) mOvf = 1'b1;
      mFull[mSel] = 1'b1;
      mSel = (mSel + 1) % NB;
    end
    checkWrites(nW, b);
    chk("line_done_count", 32'(doneCnt), 32'(acc));
    if (acc) chk("line_len", 32'(lastLen), 32'(nW));
    chk("clear_count", 32'(clrCnt), 32'(acc));
    chk("buf_full", 32'(bufFull), 32'(mFull));
    chk("buf_select", 32'(buffSelect), 32'(mSel));
    chk("overflow", 32'(overflow), 32'(mOvf));
  endtask

  initial begin
    bit seen;
    tbl[0] = '{1'b0, 2'b00, 4, 1'b0, 0, 4, 4, 1, 2'b01, 1, 1'b0};
    tbl[1] = '{1'b0, 2'b00, 4, 1'b0, 1, 4, 4, 1, 2'b11, 0, 1'b0};
    tbl[2] = '{1'b0, 2'b00, 3, 1'b0, 0, 0, 0, 0, 2'b11, 0, 1'b1};
    tbl[3] = '{1'b1, 2'b11, 6, 1'b0, 0, 4, 4, 1, 2'b01, 1, 1'b1};
    tbl[4] = '{1'b0, 2'b00, 2, 1'b1, 1, 2, 2, 1, 2'b11, 0, 1'b1};
    tbl[5] = '{1'b0, 2'b01, 1, 1'b0, 0, 1, 1, 1, 2'b11, 1, 1'b1};

    gap(3);
    chk("reset_outputs",
        {pixOutput, pixAddr, writeBuff, buffClear, buffSelect, bufFull,
         lineDone, lineLen, frameStart, overflow}, 32'd0);
    camRSTn = 1'b1;
    gap(4);

    for (int v = 0; v < 6; v++) begin
      if (tbl[v].rel != '0) pulseRelease(tbl[v].rel);
      if (tbl[v].vs) vsyncPulse();
      fillPattern();
      runLine(tbl[v].nPix, tbl[v].part);
      checkWrites(tbl[v].expW, tbl[v].expBuf);
      chk("tbl_line_done", 32'(doneCnt), 32'(tbl[v].expDone));
      if (tbl[v].expDone != 0) chk("tbl_line_len", 32'(lastLen), 32'(tbl[v].expLen));
      chk("tbl_buf_full", 32'(bufFull), 32'(tbl[v].expFull));
      chk("tbl_buf_select", 32'(buffSelect), 32'(tbl[v].expSel));
      chk("tbl_overflow", 32'(overflow), 32'(tbl[v].expOvf));
    end
    mFull = tbl[5].expFull;
    mSel  = tbl[5].expSel;
    mOvf  = tbl[5].expOvf;

    // VSYNC raised after two pixels of a line going to buffer 1.
    pulseRelease(2'b11);
    fillPattern();
    clearObs();
    fsCnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge camPCLK);
      HREF = 1'b1;
      pixData = lb[k];
      if (k == 5) camVSYNC = 1'b1;
    end
    @(negedge camPCLK);
    HREF = 1'b0;
    pixData = '0;
    gap(3);
    camVSYNC = 1'b0;
    gap(6);
    checkWrites(2, 1);
    chk("vsync_mid_no_line_done", 32'(doneCnt), 32'd0);
    chk("vsync_mid_buf_full", 32'(bufFull), 32'd0);
    chk("vsync_mid_buf_select", 32'(buffSelect), 32'd0);
    chk("vsync_mid_frameStart", 32'(fsCnt), 32'd1);
    mFull = '0;
    mSel = 0;
    mOvf = 1'b0;

    // Release of buffer 0 in the very cycle its line is committed.
    fillPattern();
    clearObs();
    driveBytes(8);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge camPCLK);
      if (lineDone) begin
        seen = 1'b1;
        bufRelease = 2'b01;
        @(negedge camPCLK);
        bufRelease = '0;
      end
    end
    chk("release_at_commit_seen", 32'(seen), 32'd1);
    gap(3);
    chk("release_at_commit_buf_full", 32'(bufFull), 32'b01);
    chk("release_at_commit_buf_select", 32'(buffSelect), 32'd1);
    mFull = 2'b01;
    mSel = 1;

    // Reset asserted mid-line, released while HREF is still high.
    fillPattern();
    clearObs();
    for (int k = 0; k < 5; k++) begin
      @(negedge camPCLK);
      HREF = 1'b1;
      pixData = lb[k];
    end
    @(negedge camPCLK);
    pixData = lb[5];
    camRSTn = 1'b0;
    #1;
    chk("async_reset_outputs",
        {pixOutput, pixAddr, writeBuff, buffClear, buffSelect, bufFull,
         lineDone, lineLen, frameStart, overflow}, 32'd0);
    for (int k = 6; k < 8; k++) begin
      @(negedge camPCLK);
      pixData = lb[k];
    end
    @(negedge camPCLK);
    camRSTn = 1'b1;
    clearObs();
    for (int k = 0; k < 6; k++) begin
      @(negedge camPCLK);
      pixData = lb[k];
    end
    @(negedge camPCLK);
    HREF = 1'b0;
    pixData = '0;
    gap(6);
    chk("reset_midline_writes", 32'(wrQ.size()), 32'd0);
    chk("reset_midline_line_done", 32'(doneCnt), 32'd0);
    chk("reset_midline_clears", 32'(clrCnt), 32'd0);
    mFull = '0;
    mSel = 0;
    mOvf = 1'b0;
    fillPattern();
    runLine(3, 1'b0);
    checkLine(3);

    for (int r = 0; r < 30; r++) begin
      int nPix;
      bit part;
      logic [NB-1:0] rel;
      if ($urandom_range(0, 5) == 0) vsyncPulse();
      rel = NB'($urandom_range(0, 3));
      if (rel != '0) pulseRelease(rel);
      for (int k = 0; k < 16; k++) lb[k] = 8'($urandom);
      nPix = $urandom_range(1, 6);
      part = 1'($urandom_range(0, 1));
      runLine(nPix, part);
      checkLine(nPix);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
